// File: rtl/signed_vector_normalize_pkg.sv
// Shared definitions for the signed vector normaliser.
//   - Component and vector widths and the derived datapath widths.
//   - Component slice helpers for the packed {x, y, z} vector.
//   - The FSM state encoding.
//   - A 19-bit magnitude helper. It is exact for the most negative component.
package signed_vector_normalize_pkg;

  localparam int COMP_W     = 19;              // signed Q8.10 component
  localparam int FRAC_W     = 10;              // fraction bits per component
  localparam int VEC_W      = 3 * COMP_W;      // packed {x, y, z}
  localparam int SUM_W      = 2 * COMP_W;      // x^2+y^2+z^2, 20 fraction bits
  localparam int DIVD_W     = COMP_W + FRAC_W; // |c| << FRAC_W
  localparam int SQRT_ITERS = SUM_W / 2;       // one root bit per two sum bits

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SQUARE = 3'd1,
    S_SQRT   = 3'd2,
    S_DIV    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  function automatic logic [COMP_W-1:0] comp_x(input logic [VEC_W-1:0] v);
    return v[3*COMP_W-1:2*COMP_W];
  endfunction

  function automatic logic [COMP_W-1:0] comp_y(input logic [VEC_W-1:0] v);
    return v[2*COMP_W-1:COMP_W];
  endfunction

  function automatic logic [COMP_W-1:0] comp_z(input logic [VEC_W-1:0] v);
    return v[COMP_W-1:0];
  endfunction

  // Two's-complement magnitude read back as unsigned.
  // -2^18 maps to 2^18, which still fits in COMP_W unsigned bits.
  function automatic logic [COMP_W-1:0] abs_comp(input logic [COMP_W-1:0] c);
    return c[COMP_W-1] ? ((~c) + {{(COMP_W-1){1'b0}}, 1'b1}) : c;
  endfunction

endpackage

// File: rtl/unsigned_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle, MSB first.
// A division takes exactly DIVD_W (29) rising edges. The first bit is resolved
// on the same edge that samples start.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        sample dividend/divisor and resolve the first quotient bit
//   dividend     DIVD_W-bit unsigned dividend
//   divisor      COMP_W-bit unsigned divisor, nonzero
//   busy         a division is in progress (start must stay low)
//   done         the cycle ending in the last iteration edge.
//                quotient is valid only while done is high.
//   quotient     DIVD_W-bit unsigned quotient, including the final bit
module unsigned_restoring_divider
  import signed_vector_normalize_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIVD_W-1:0] dividend,
  input  logic [COMP_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DIVD_W-1:0] quotient
);

  logic [4:0]        cnt;     // iterations completed so far
  logic [COMP_W-1:0] rem;
  logic [COMP_W-1:0] dsr;
  logic [DIVD_W-2:0] dvd;     // dividend bits not yet shifted in
  logic [DIVD_W-2:0] quo;     // quotient bits resolved so far

  logic [COMP_W-1:0] src_rem;
  logic [COMP_W-1:0] src_dsr;
  logic              src_bit;
  logic [COMP_W:0]   shifted;
  logic [COMP_W:0]   dsr_ext;
  logic              qbit;
  logic [COMP_W-1:0] next_rem;

  // On start the step works on the fresh operands rather than the registers.
  // This lets the load edge also resolve the first quotient bit.
  always_comb begin
    src_rem  = start ? '0 : rem;
    src_bit  = start ? dividend[DIVD_W-1] : dvd[DIVD_W-2];
    src_dsr  = start ? divisor : dsr;
    shifted  = {src_rem, src_bit};
    dsr_ext  = {1'b0, src_dsr};
    qbit     = (shifted >= dsr_ext);
    // A restored remainder is always below the divisor, so it fits COMP_W bits.
    next_rem = qbit ? COMP_W'(shifted - dsr_ext) : shifted[COMP_W-1:0];
  end

  assign done     = busy && (cnt == 5'(DIVD_W - 1));
  assign quotient = {quo, qbit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
      dsr  <= '0;
      dvd  <= '0;
      quo  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= 5'd1;
      rem  <= next_rem;
      dsr  <= divisor;
      dvd  <= dividend[DIVD_W-2:0];
      quo  <= {{(DIVD_W-2){1'b0}}, qbit};
    end else if (busy) begin
      rem <= next_rem;
      dvd <= {dvd[DIVD_W-3:0], 1'b0};
      quo <= {quo[DIVD_W-3:0], qbit};
      if (cnt == 5'(DIVD_W - 1)) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 5'd1;
      end
    end
  end

endmodule

// File: rtl/signed_vector_normalize.sv
// Iterative unit-vector stage for a packed 3x19-bit signed Q8.10 vector.
// Each vector goes through four steps:
//   - one squaring cycle;
//   - a 19-cycle restoring integer square root giving mag = floor(sqrt(S));
//   - three 29-cycle divisions q = floor((|c| << 10) / mag), in x, y, z order;
//   - each q takes the sign of its component, so it truncates toward zero.
// A zero-magnitude input skips straight to DONE with zero_vec set.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_vector = {x, y, z}
//   out_valid/out_ready output handshake; out_vector = normalised {x, y, z}
//   zero_vec            input had zero magnitude, out_vector is 0
//   state_dbg           current FSM state (state_t encoding)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer keeps valid (and data) until then. ready never depends
// combinationally on valid. in_ready is high only in IDLE. out_valid is high
// only in DONE, with out_vector/zero_vec held stable. After an output transfer
// in_ready rises on the next edge. Accept and output never overlap.
module signed_vector_normalize
  import signed_vector_normalize_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] in_vector,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VEC_W-1:0] out_vector,
  output logic             zero_vec,
  output logic [2:0]       state_dbg
);

  state_t            state;
  logic [COMP_W-1:0] cx, cy, cz;
  logic [SUM_W-1:0]  sq_bits;   // radicand, consumed two bits per cycle
  logic [COMP_W+1:0] sq_rem;
  logic [COMP_W-1:0] root;
  logic [COMP_W-1:0] mag;
  logic [4:0]        sq_cnt;
  logic [1:0]        comp_idx;  // 0 = x, 1 = y, 2 = z

  logic [COMP_W-1:0] ax, ay, az;
  logic [SUM_W-1:0]  sum_sq;
  logic [COMP_W+3:0] sq_shifted;
  logic [COMP_W+3:0] sq_trial;
  logic              sq_ge;
  logic [COMP_W+1:0] sq_next_rem;
  logic [COMP_W-1:0] root_next;

  logic              div_start;
  logic              div_busy;
  logic              div_done;
  logic [DIVD_W-1:0] div_quotient;
  logic [COMP_W-1:0] sel_c;
  logic [COMP_W-1:0] q_low;
  logic [COMP_W-1:0] div_result;
  logic              unused_q_hi;

  assign state_dbg = state;

  // The sum of squares is at most 3*2^36, which fits SUM_W bits.
  always_comb begin
    ax     = abs_comp(cx);
    ay     = abs_comp(cy);
    az     = abs_comp(cz);
    sum_sq = SUM_W'(ax) * SUM_W'(ax) + SUM_W'(ay) * SUM_W'(ay) + SUM_W'(az) * SUM_W'(az);
  end

  // One restoring square-root step.
  // Bring down the next two radicand bits and trial-subtract (root << 2) | 1.
  // A restored remainder never exceeds 2*root, so it fits COMP_W+2 bits.
  always_comb begin
    sq_shifted  = {sq_rem, sq_bits[SUM_W-1:SUM_W-2]};
    sq_trial    = {2'b00, root, 2'b01};
    sq_ge       = (sq_shifted >= sq_trial);
    sq_next_rem = sq_ge ? (COMP_W+2)'(sq_shifted - sq_trial) : sq_shifted[COMP_W+1:0];
    root_next   = {root[COMP_W-2:0], sq_ge};
  end

  // The divider is restarted whenever it is idle in DIV.
  // The component index has already advanced by then.
  always_comb begin
    div_start = (state == S_DIV) && !div_busy;
    case (comp_idx)
      2'd0:    sel_c = cx;
      2'd1:    sel_c = cy;
      default: sel_c = cz;
    endcase
    // mag >= |c|, so the quotient never exceeds 1024 and fits COMP_W bits.
    q_low       = div_quotient[COMP_W-1:0];
    div_result  = sel_c[COMP_W-1] ? ((~q_low) + {{(COMP_W-1){1'b0}}, 1'b1}) : q_low;
    unused_q_hi = ^div_quotient[DIVD_W-1:COMP_W];
  end

  unsigned_restoring_divider u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend ({abs_comp(sel_c), {FRAC_W{1'b0}}}),
    .divisor  (mag),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_vector <= '0;
      zero_vec   <= 1'b0;
      cx         <= '0;
      cy         <= '0;
      cz         <= '0;
      sq_bits    <= '0;
      sq_rem     <= '0;
      root       <= '0;
      mag        <= '0;
      sq_cnt     <= '0;
      comp_idx   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            cx         <= comp_x(in_vector);
            cy         <= comp_y(in_vector);
            cz         <= comp_z(in_vector);
            in_ready   <= 1'b0;
            out_vector <= '0;
            zero_vec   <= 1'b0;
            state      <= S_SQUARE;
          end
        end
        S_SQUARE: begin
          if (sum_sq == '0) begin
            zero_vec   <= 1'b1;
            out_vector <= '0;
            out_valid  <= 1'b1;
            state      <= S_DONE;
          end else begin
            sq_bits <= sum_sq;
            sq_rem  <= '0;
            root    <= '0;
            sq_cnt  <= '0;
            state   <= S_SQRT;
          end
        end
        S_SQRT: begin
          sq_rem  <= sq_next_rem;
          root    <= root_next;
          sq_bits <= {sq_bits[SUM_W-3:0], 2'b00};
          if (sq_cnt == 5'(SQRT_ITERS - 1)) begin
            mag      <= root_next;
            comp_idx <= 2'd0;
            state    <= S_DIV;
          end else begin
            sq_cnt <= sq_cnt + 5'd1;
          end
        end
        S_DIV: begin
          if (div_done) begin
            case (comp_idx)
              2'd0:    out_vector[3*COMP_W-1:2*COMP_W] <= div_result;
              2'd1:    out_vector[2*COMP_W-1:COMP_W]   <= div_result;
              default: out_vector[COMP_W-1:0]          <= div_result;
            endcase
            if (comp_idx == 2'd2) begin
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              comp_idx <= comp_idx + 2'd1;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_vector_normalize.sv
module tb_signed_vector_normalize;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [56:0] in_vector;
  logic        out_valid;
  logic        out_ready;
  logic [56:0] out_vector;
  logic        zero_vec;
  logic [2:0]  state_dbg;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam int LAT_NONZERO = 107;
  localparam int LAT_ZERO    = 1;

  signed_vector_normalize dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_vector  (in_vector),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_vector (out_vector),
    .zero_vec   (zero_vec),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [56:0] pack3(input int x, input int y, input int z);
    return {19'(x), 19'(y), 19'(z)};
  endfunction

  // Normalise using plain integer arithmetic.
  // mag = floor(sqrt(x^2+y^2+z^2)).
  // Each component = sign(c) * floor(|c| * 1024 / mag).
  function automatic logic [56:0] model_norm(input logic [56:0] v, output bit zero);
    longint      c [3];
    longint      s, mag, q, a;
    logic [18:0] raw;
    logic [56:0] res;
    raw = v[56:38]; c[0] = longint'($signed(raw));
    raw = v[37:19]; c[1] = longint'($signed(raw));
    raw = v[18:0];  c[2] = longint'($signed(raw));
    s = c[0] * c[0] + c[1] * c[1] + c[2] * c[2];
    zero = (s == 0);
    if (zero) return '0;
    mag = longint'($floor($sqrt(real'(s))));
    while (mag * mag > s) mag--;
    while ((mag + 1) * (mag + 1) <= s) mag++;
    res = '0;
    for (int i = 0; i < 3; i++) begin
      a = (c[i] < 0) ? -c[i] : c[i];
      q = (a * 1024) / mag;
      res[56 - 19 * i -: 19] = 19'((c[i] < 0) ? -q : q);
    end
    return res;
  endfunction

  function automatic logic [18:0] rand_comp();
    case ($urandom_range(0, 3))
      0:       return 19'($urandom);
      1:       return 19'(int'($urandom_range(0, 4094)) - 2047);
      2:       return 19'd0;
      default: return ($urandom_range(0, 1) == 1) ? 19'h40000 : 19'h3FFFF;
    endcase
  endfunction

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic accept_vec(input logic [56:0] v, output bit ok);
    int guard = 0;
    while (in_ready !== 1'b1 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    ok = (in_ready === 1'b1);
    in_valid  = 1'b1;
    in_vector = v;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    in_vector = 57'({$urandom, $urandom});
  endtask

  task automatic wait_out(output int lat, output bit ok);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 300) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    ok = (out_valid === 1'b1);
  endtask

  task automatic take_output();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vector = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_vector !== '0 || zero_vec !== 1'b0 || state_dbg !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b out_vector=%h zero_vec=%b state=%0d, required 1 0 0 0 0",
               in_ready, out_valid, out_vector, zero_vec, state_dbg);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [56:0] vin  [6];
    logic [56:0] vexp [6];
    bit          zexp [6];
    bit          ok_a, ok_o;
    int          lat;
    vin[0] = pack3(3072, 4096, 0);          vexp[0] = pack3(614, 819, 0);        zexp[0] = 0;
    vin[1] = pack3(-2048, 0, 0);            vexp[1] = pack3(-1024, 0, 0);        zexp[1] = 0;
    vin[2] = pack3(0, -2048, 0);            vexp[2] = pack3(0, -1024, 0);        zexp[2] = 0;
    vin[3] = pack3(0, 0, -2048);            vexp[3] = pack3(0, 0, -1024);        zexp[3] = 0;
    vin[4] = pack3(0, 0, 0);                vexp[4] = '0;                        zexp[4] = 1;
    vin[5] = pack3(-262144, -262144, -262144); vexp[5] = pack3(-591, -591, -591); zexp[5] = 0;
    for (int i = 0; i < 6; i++) begin
      accept_vec(vin[i], ok_a);
      wait_out(lat, ok_o);
      tests_run++;
      if (!(ok_a && ok_o)) begin
        tests_failed++;
        $display("FAIL directed_%0d_handshake: accepted=%b out_valid_seen=%b, required 1 1", i, ok_a, ok_o);
      end
      tests_run++;
      if (out_vector !== vexp[i] || zero_vec !== zexp[i]) begin
        tests_failed++;
        $display("FAIL directed_%0d_result: out_vector=%h zero_vec=%b, required %h %b", i, out_vector, zero_vec, vexp[i], zexp[i]);
      end
      tests_run++;
      if (lat != (zexp[i] ? LAT_ZERO : LAT_NONZERO)) begin
        tests_failed++;
        $display("FAIL directed_%0d_latency: %0d edges, required %0d", i, lat, zexp[i] ? LAT_ZERO : LAT_NONZERO);
      end
      take_output();
    end
  endtask

  task automatic test_random();
    logic [56:0] v, exp_v;
    bit          ez, ok_a, ok_o;
    int          lat;
    for (int n = 0; n < 24; n++) begin
      v     = {rand_comp(), rand_comp(), rand_comp()};
      exp_v = model_norm(v, ez);
      accept_vec(v, ok_a);
      wait_out(lat, ok_o);
      tests_run++;
      if (!(ok_a && ok_o) || out_vector !== exp_v || zero_vec !== ez || lat != (ez ? LAT_ZERO : LAT_NONZERO)) begin
        tests_failed++;
        $display("FAIL random_%0d: in=%h out=%h zero=%b lat=%0d, required out=%h zero=%b lat=%0d",
                 n, v, out_vector, zero_vec, lat, exp_v, ez, ez ? LAT_ZERO : LAT_NONZERO);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b1 || out_vector !== exp_v) begin
        tests_failed++;
        $display("FAIL random_%0d_hold: out_valid=%b out=%h, required 1 %h", n, out_valid, out_vector, exp_v);
      end
      take_output();
    end
  endtask

  task automatic test_back_to_back();
    logic [56:0] v, exp_v;
    bit          ez, ok_a, ok_o;
    int          lat;
    for (int n = 0; n < 3; n++) begin
      v     = pack3(int'($urandom_range(0, 20000)) - 10000, int'($urandom_range(0, 20000)) - 10000, 1 + n);
      exp_v = model_norm(v, ez);
      accept_vec(v, ok_a);
      wait_out(lat, ok_o);
      tests_run++;
      if (!(ok_a && ok_o) || out_vector !== exp_v || lat != LAT_NONZERO) begin
        tests_failed++;
        $display("FAIL back_to_back_%0d: out=%h lat=%0d, required %h %0d", n, out_vector, lat, exp_v, LAT_NONZERO);
      end
      take_output();
      tests_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL back_to_back_%0d_ready: in_ready=%b out_valid=%b, required 1 0", n, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [56:0] v1, v2, e1, e2;
    bit          ez, ok_a, ok_o;
    int          lat;
    v1 = pack3(-5000, 1234, 777);
    e1 = model_norm(v1, ez);
    v2 = pack3(100, -300, 900);
    e2 = model_norm(v2, ez);
    accept_vec(v1, ok_a);
    wait_out(lat, ok_o);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_vector !== e1 || zero_vec !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_hold_%0d: out_valid=%b in_ready=%b out=%h, required 1 0 %h", i, out_valid, in_ready, out_vector, e1);
      end
    end
    // Release the output and offer a new vector on the same edge.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_vector = v2;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || state_dbg !== 3'd0) begin
      tests_failed++;
      $display("FAIL stall_reject: out_valid=%b in_ready=%b state=%0d, required 0 1 0", out_valid, in_ready, state_dbg);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    in_vector = '0;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_accept: in_ready=%b, required 0", in_ready);
    end
    wait_out(lat, ok_o);
    tests_run++;
    if (!ok_o || out_vector !== e2 || zero_vec !== 1'b0 || lat != LAT_NONZERO) begin
      tests_failed++;
      $display("FAIL stall_second: out=%h zero=%b lat=%0d, required %h 0 %0d", out_vector, zero_vec, lat, e2, LAT_NONZERO);
    end
    take_output();
  endtask

  task automatic test_reset_mid();
    logic [56:0] v, exp_v;
    bit          ez, ok_a, ok_o;
    int          lat;
    accept_vec(pack3(3072, 4096, 0), ok_a);
    repeat (50) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_vector !== '0 || zero_vec !== 1'b0 || state_dbg !== 3'd0) begin
      tests_failed++;
      $display("FAIL mid_reset: out_valid=%b in_ready=%b out=%h zero=%b state=%0d, required 0 1 0 0 0",
               out_valid, in_ready, out_vector, zero_vec, state_dbg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    v     = pack3(-1500, 700, 2500);
    exp_v = model_norm(v, ez);
    accept_vec(v, ok_a);
    wait_out(lat, ok_o);
    tests_run++;
    if (!(ok_a && ok_o) || out_vector !== exp_v || zero_vec !== 1'b0 || lat != LAT_NONZERO) begin
      tests_failed++;
      $display("FAIL after_reset: out=%h zero=%b lat=%0d, required %h 0 %0d", out_vector, zero_vec, lat, exp_v, LAT_NONZERO);
    end
    take_output();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
